lsb_deb: RTL and testbench

Debounce and event-capture stage downstream of the LEDs/switches/buttons I/O block. It takes the already two-flop-synchronised button and switch vectors and filters each bit with a tick-based stability counter. It detects button press and release edges and latches them into sticky, software-clearable flags with a maskable interrupt. Software reads it on the internal bus as two word registers.

---
 rtl/lsb_deb.sv | 136 +++++++++++++
 tb/tb_lsb_deb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_deb.sv
// lsb_deb: debounce and event capture for buttons and switches.
//
// Filters the already-synchronised button (4) and switch (18) vectors with a
// tick-based stability counter, turns debounced button transitions into
// one-cycle press/release pulses, latches those into sticky W1C flags and
// raises a maskable interrupt on pending presses.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stb, we, addr     bus strobe, write enable, register select
//                     (0 = levels, 1 = events/mask)
//   data_in           bus write data
//   data_out          bus read data, zero unless stb & ~we
//   ack               bus acknowledge (= stb, zero wait states)
//   btn_in, swi_in    synchronised raw buttons / switches
//   btn_deb, swi_deb  debounced levels
//   btn_press/btn_rel one-cycle pulses on debounced button 0->1 / 1->0
//   irq               |(press_flg & irq_mask)
module lsb_deb #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  input  logic [3:0]  btn_in,
  input  logic [17:0] swi_in,
  output logic [3:0]  btn_deb,
  output logic [17:0] swi_deb,
  output logic [3:0]  btn_press,
  output logic [3:0]  btn_rel,
  output logic        irq
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned NB = 22;
  localparam logic [3:0] CNT_LAST = 4'(STABLE_TICKS - 1);

  logic [PW-1:0]     pre_cnt;
  logic              tick;
  logic [NB-1:0]     raw;
  logic [NB-1:0]     stable;
  logic [NB-1:0]     stable_nxt;
  logic [NB-1:0][3:0] cnt;
  logic [NB-1:0][3:0] cnt_nxt;
  logic [3:0]        press_flg;
  logic [3:0]        rel_flg;
  logic [3:0]        irq_mask;
  logic              wr_evt;
  logic [3:0]        clr_press;
  logic [3:0]        clr_rel;
  logic              unused_data;

  assign unused_data = ^data_in[31:12];

  // Sample tick prescaler
  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) pre_cnt <= '0;
    else             pre_cnt <= pre_cnt + 1'b1;
  end

  // Bits [3:0] are buttons, [21:4] are switches.
  assign raw = {swi_in, btn_in};

  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = cnt;
    if (tick) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (raw[i] == stable[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = raw[i];
          cnt_nxt[i]    = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + 4'd1;
        end
      end
    end
  end

  // Pulses are registered alongside the level so they coincide with the
  // first cycle the new debounced level is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable    <= '0;
      cnt       <= '0;
      btn_press <= '0;
      btn_rel   <= '0;
    end else begin
      stable    <= stable_nxt;
      cnt       <= cnt_nxt;
      btn_press <= stable_nxt[3:0] & ~stable[3:0];
      btn_rel   <= ~stable_nxt[3:0] & stable[3:0];
    end
  end

  assign btn_deb = stable[3:0];
  assign swi_deb = stable[21:4];

  // Event flags; a set in the same cycle as its clear wins.
  assign wr_evt    = stb & we & addr;
  assign clr_press = wr_evt ? data_in[3:0] : 4'b0;
  assign clr_rel   = wr_evt ? data_in[7:4] : 4'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      press_flg <= '0;
      rel_flg   <= '0;
      irq_mask  <= '0;
    end else begin
      press_flg <= (press_flg & ~clr_press) | btn_press;
      rel_flg   <= (rel_flg & ~clr_rel) | btn_rel;
      if (wr_evt) irq_mask <= data_in[11:8];
    end
  end

  assign irq = |(press_flg & irq_mask);
  assign ack = stb;

  always_comb begin
    data_out = '0;
    if (stb && !we) begin
      if (addr) data_out = {20'b0, irq_mask, rel_flg, press_flg};
      else      data_out = {6'b0, stable[21:12], 4'b0, stable[3:0], stable[11:4]};
    end
  end

endmodule

// File: tb/tb_lsb_deb.sv
// Bench for lsb_deb with TICK_DIV=4, STABLE_TICKS=3: directed scenarios with
// literal expectations, then randomized inputs and bus traffic, all compared
// every cycle against a window-based behavioural model.
module tb_lsb_deb;

  localparam int TD = 4;
  localparam int ST = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic        we;
  logic        addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic [3:0]  btn_in;
  logic [17:0] swi_in;
  logic [3:0]  btn_deb;
  logic [17:0] swi_deb;
  logic [3:0]  btn_press;
  logic [3:0]  btn_rel;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsb_deb #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ack(ack),
    .btn_in(btn_in), .swi_in(swi_in), .btn_deb(btn_deb), .swi_deb(swi_deb),
    .btn_press(btn_press), .btn_rel(btn_rel), .irq(irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a level is accepted once the last ST tick samples
  // all disagree with the current debounced level.
  int unsigned   m_cyc;
  logic [ST-1:0] m_hist [22];
  logic [21:0]   m_stable;
  logic [3:0]    m_press, m_rel, m_pflg, m_rflg, m_mask;
  bit            m_valid = 0;

  always @(posedge clk) begin : model
    logic [21:0]   raw_s, nst;
    logic [ST-1:0] h;
    logic [3:0]    clrp, clrr;
    bit            tk, wr;
    if (rst) begin
      m_cyc <= 0;
      for (int i = 0; i < 22; i++) m_hist[i] <= '0;
      m_stable <= '0;
      m_press <= '0; m_rel <= '0; m_pflg <= '0; m_rflg <= '0; m_mask <= '0;
      m_valid <= 1;
    end else begin
      raw_s = {swi_in, btn_in};
      nst   = m_stable;
      tk    = ((m_cyc % TD) == TD - 1);
      m_cyc <= m_cyc + 1;
      if (tk) begin
        for (int i = 0; i < 22; i++) begin
          h = {m_hist[i][ST-2:0], raw_s[i]};
          m_hist[i] <= h;
          if (h == {ST{~m_stable[i]}}) nst[i] = ~m_stable[i];
        end
      end
      m_stable <= nst;
      m_press  <= nst[3:0] & ~m_stable[3:0];
      m_rel    <= ~nst[3:0] & m_stable[3:0];
      wr   = stb && we && addr;
      clrp = wr ? data_in[3:0] : 4'h0;
      clrr = wr ? data_in[7:4] : 4'h0;
      m_pflg <= (m_pflg & ~clrp) | m_press;
      m_rflg <= (m_rflg & ~clrr) | m_rel;
      if (wr) m_mask <= data_in[11:8];
    end
  end

  function automatic logic [31:0] exp_rd();
    if (stb && !we) begin
      if (addr) return {20'b0, m_mask, m_rflg, m_pflg};
      return {6'b0, m_stable[21:12], 4'b0, m_stable[3:0], m_stable[11:4]};
    end
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("btn_deb",   btn_deb,   m_stable[3:0]);
      chk("swi_deb",   swi_deb,   m_stable[21:4]);
      chk("btn_press", btn_press, m_press);
      chk("btn_rel",   btn_rel,   m_rel);
      chk("irq",       irq,       |(m_pflg & m_mask));
      chk("ack",       ack,       stb);
      chk("data_out",  data_out,  exp_rd());
    end
  end

  // Inputs change 2 time units after the rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic rd(input logic a, input string name, input logic [31:0] exp);
    stb = 1'b1; we = 1'b0; addr = a;
    #1;
    chk(name, data_out, exp);
    cyc(1);
    stb = 1'b0;
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    stb = 1'b1; we = 1'b1; addr = a; data_in = d;
    cyc(1);
    stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  first, lat, pulses;
    bit  found;
    int  hold;

    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 1'b0; data_in = '0;
    btn_in = 4'hF; swi_in = '0;

    // Reset with all buttons held
    cyc(2);
    stb = 1'b1; addr = 1'b1;
    #1;
    chk("rst_rd1", data_out, 32'h0);
    chk("rst_btn_deb", btn_deb, 4'h0);
    stb = 1'b0;
    rst = 1'b0;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (btn_deb == 4'hF) begin
        first = k;
        break;
      end
    end
    #1;
    chk("rst_deb_lat", (first >= 9 && first <= 12), 1);

    btn_in = 4'h0; rst = 1'b1;
    cyc(2);
    rst = 1'b0;

    // Press button 0
    btn_in = 4'h1;
    lat = 0; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (btn_press[0]) pulses++;
      if (btn_deb[0] && lat == 0) lat = k;
    end
    #1;
    chk("press_lat", (lat >= 1 && lat <= 12), 1);
    chk("press_pulses", pulses, 1);
    rd(1'b1, "press_rd", 32'h001);

    // Glitch on button 1
    btn_in = 4'h3;
    cyc(6);
    btn_in = 4'h1;
    cyc(16);
    chk("glitch_deb", btn_deb[1], 1'b0);
    rd(1'b1, "glitch_rd", 32'h001);

    // Interrupt and W1C
    btn_in = 4'h0;
    cyc(16);
    wr(1'b1, 32'h0FF);
    wr(1'b1, 32'h100);
    btn_in = 4'h1;
    cyc(16);
    chk("irq_set", irq, 1'b1);
    wr(1'b1, 32'h101);
    chk("irq_clr", irq, 1'b0);
    rd(1'b1, "w1c_rd", 32'h100);
    btn_in = 4'h0;
    cyc(16);
    rd(1'b1, "rel_rd", 32'h110);
    chk("irq_rel", irq, 1'b0);

    // Set beats clear on press_flg[2]
    btn_in = 4'h4;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (btn_press[2]) begin
        found = 1;
        #1;
        stb = 1'b1; we = 1'b1; addr = 1'b1; data_in = 32'h104;
        cyc(1);
        stb = 1'b0; we = 1'b0;
        break;
      end
    end
    if (!found) #1;
    chk("sbc_seen", found, 1);
    rd(1'b1, "sbc_rd", 32'h114);

    // Switches
    btn_in = 4'h0;
    cyc(16);
    rd(1'b1, "pre_swi_rd", 32'h154);
    swi_in = 18'h20005;
    cyc(14);
    rd(1'b0, "swi_rd", 32'h0200_0005);
    rd(1'b1, "swi_flags", 32'h154);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      hold   = $urandom_range(1, 24);
      btn_in = btn_in ^ (4'($urandom) & 4'($urandom));
      swi_in = swi_in ^ (18'($urandom) & 18'($urandom));
      rst    = ($urandom_range(0, 59) == 0);
      for (int j = 0; j < hold; j++) begin
        stb     = ($urandom_range(0, 3) == 0);
        we      = 1'($urandom_range(0, 1));
        addr    = 1'($urandom_range(0, 1));
        data_in = $urandom;
        cyc(1);
        rst = 1'b0;
      end
    end
    stb = 1'b0; we = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
